// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and the wait-state counter width.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_W   = 4;
    localparam int LAT_MAX = (1 << LAT_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extension for loads, and the
// misaligned / illegal-funct3 check. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic        err,
    output logic [31:0] rdata
);

    logic        illegal;
    logic        misal;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        illegal = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = we;
            default:          illegal = 1'b1;
        endcase
    end

    always_comb begin
        misal = 1'b0;
        case (funct3[1:0])
            2'b01:   misal = addr_lo[0];
            2'b10:   misal = (addr_lo != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    assign err = illegal | misal;

    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wword = wdata;
            end
            default: begin
                be    = 4'b0000;
                wword = wdata;
            end
        endcase
        if (err) be = 4'b0000;
    end

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
            F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'h0, rbyte};
            F3_HU:   rdata = {16'h0, rhalf};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit with byte-addressed RAM and wait-state latency.
// Optional LSU_PERF_CNT_EN adds load/store/error performance counters.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]     perf_loads,
    output logic [31:0]     perf_stores,
    output logic [31:0]     perf_errors,
`endif
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    if (XLEN != 32) begin : g_bad_xlen
        $error("lsu_mem: only XLEN=32 is supported");
    end
    if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_bad_lat
        $error("lsu_mem: LATENCY out of range");
    end
    if (DEPTH_WORDS < 4 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
        $error("lsu_mem: DEPTH_WORDS must be a power of two >= 4");
    end

    lsu_state_t       state;
    lsu_state_t       next;
    logic [LAT_W-1:0] cnt;
    logic             accept;
    logic [AW-1:0]    idx;
    logic [XLEN-1:0]  rword;
    logic [XLEN-1:0]  wword;
    logic [XLEN-1:0]  ext;
    logic [3:0]       be;
    logic             err;
    logic             unused;

    logic [XLEN-1:0] ram [DEPTH_WORDS];

    assign accept = req_valid & req_ready;
    assign idx    = req_addr[AW+1:2];
    assign rword  = ram[idx];
    assign unused = ^req_addr[XLEN-1:AW+2];

    lsu_align u_align (
        .we      (req_we),
        .funct3  (req_funct3),
        .addr_lo (req_addr[1:0]),
        .wdata   (req_wdata),
        .rword   (rword),
        .be      (be),
        .wword   (wword),
        .err     (err),
        .rdata   (ext)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (accept) next = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == '0) next = RESP;
            RESP: if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset)               cnt <= '0;
        else if (accept)         cnt <= LAT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
        else if (state == WAIT)  cnt <= cnt - 1'b1;
    end

    // Load data is extended at acceptance, so the response is a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (req_we || err) ? '0 : ext;
            rsp_err   <= err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errors <= '0;
        end else if (accept) begin
            if (err)         perf_errors <= perf_errors + 1'b1;
            else if (req_we) perf_stores <= perf_stores + 1'b1;
            else             perf_loads  <= perf_loads + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem.sv
// Randomised self-checking bench for lsu_mem against a byte-array model.
// Build with LSU_PERF_CNT_EN defined to also check the counters.
module tb_lsu_mem;

    localparam int LAT = 3;
    localparam int DW  = 1024;
    localparam int MB  = DW * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errors;
`endif

    lsu_mem #(
        .XLEN        (32),
        .DEPTH_WORDS (DW),
        .LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
`ifdef LSU_PERF_CNT_EN
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errors (perf_errors),
`endif
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] mem_m [MB];
    int m_loads  = 0;
    int m_stores = 0;
    int m_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef LSU_PERF_CNT_EN
        check({tag, " perf_loads"},  perf_loads,  32'(m_loads));
        check({tag, " perf_stores"}, perf_stores, 32'(m_stores));
        check({tag, " perf_errors"}, perf_errors, 32'(m_errs));
`else
        n_chk += 0;
`endif
    endtask

    // Reference: byte-granular memory, size/legality from the RV32I table.
    task automatic model(input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output bit er);
        int size;
        bit legal;
        bit sgn;
        int a;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = we ? (f3 <= 3'd2) : (size != 0);
        sgn   = (f3 < 3'd4);
        a     = int'(addr % 32'(MB));
        rd    = '0;
        er    = !legal || (a % size != 0);
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) mem_m[a + i] = 8'(wdata >> (8 * i));
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
            if (sgn && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endtask

    // Starts and ends just after a falling edge with the unit idle.
    task automatic xact(input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input string tag,
                        output logic [31:0] got, output logic got_err);
        logic [31:0] erd;
        bit eer;
        int k;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        model(we, f3, addr, wdata, erd, eer);
        if (eer)     m_errs++;
        else if (we) m_stores++;
        else         m_loads++;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        k = 0;
        while (!rsp_valid && k < 40) begin
            check({tag, " busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        got     = rsp_rdata;
        got_err = rsp_err;
        if (!rsp_valid) begin
            check({tag, " timeout"}, 32'(rsp_valid), 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(k), 32'(LAT));
        check({tag, " rdata"}, rsp_rdata, erd);
        check({tag, " err"}, 32'(rsp_err), 32'(eer));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata, erd);
            check({tag, " hold ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " ready after"}, 32'(req_ready), 32'd1);
        check({tag, " valid after"}, 32'(rsp_valid), 32'd0);
        check_perf(tag);
    endtask

    logic [31:0] got;
    logic        gerr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        check_perf("reset");

        for (int w = 0; w < DW; w++)
            xact(1'b1, 3'd2, 32'(w * 4), $urandom, 0, "init", got, gerr);

        xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, "sw10", got, gerr);
        xact(1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13", got, gerr);
        check("lb13 const", got, 32'hFFFF_FFDE);
        xact(1'b0, 3'd4, 32'h13, 32'h0, 0, "lbu13", got, gerr);
        check("lbu13 const", got, 32'h0000_00DE);
        xact(1'b0, 3'd1, 32'h12, 32'h0, 0, "lh12", got, gerr);
        check("lh12 const", got, 32'hFFFF_DEAD);
        xact(1'b0, 3'd5, 32'h10, 32'h0, 0, "lhu10", got, gerr);
        check("lhu10 const", got, 32'h0000_BEEF);
        xact(1'b1, 3'd0, 32'h11, 32'h1234_5655, 0, "sb11", got, gerr);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 2, "lw10", got, gerr);
        check("lw10 const", got, 32'hDEAD_55EF);
        check("lw10 err const", 32'(gerr), 32'd0);
        xact(1'b0, 3'd2, 32'h12, 32'h0, 0, "lw12 mis", got, gerr);
        check("lw12 err const", 32'(gerr), 32'd1);
        xact(1'b1, 3'd1, 32'h11, 32'hFFFF_FFFF, 1, "sh11 mis", got, gerr);
        check("sh11 err const", 32'(gerr), 32'd1);
        xact(1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10 again", got, gerr);
        check("lw10 again const", got, 32'hDEAD_55EF);
        xact(1'b0, 3'd3, 32'h10, 32'h0, 0, "f3 011", got, gerr);
        check("f3 011 err const", 32'(gerr), 32'd1);
        xact(1'b1, 3'd2, 32'h1000, 32'hA5A5_A5A5, 0, "sw wrap", got, gerr);
        xact(1'b0, 3'd2, 32'h0, 32'h0, 0, "lw wrap", got, gerr);
        check("lw wrap const", got, 32'hA5A5_A5A5);

        // Store accepted, then reset while waiting: store stays committed.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'h1122_3344;
        @(posedge clk);
        model(1'b1, 3'd2, 32'h20, 32'h1122_3344, got, gerr);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_loads = 0; m_stores = 0; m_errs = 0;
        for (int i = 0; i < 6; i++) begin
            check("rst wait valid", 32'(rsp_valid), 32'd0);
            check("rst wait ready", 32'(req_ready), 32'd1);
            @(negedge clk);
        end
        check_perf("rst wait");

        // Reset on the acceptance edge blocks the write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        check_perf("rst accept");
        xact(1'b0, 3'd2, 32'h20, 32'h0, 0, "lw20", got, gerr);
        check("lw20 const", got, 32'h1122_3344);

        // Load accepted, reset after the following edge.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_loads = 0; m_stores = 0; m_errs = 0;
        for (int i = 0; i < 6; i++) begin
            check("rst load valid", 32'(rsp_valid), 32'd0);
            check("rst load ready", 32'(req_ready), 32'd1);
            @(negedge clk);
        end
        check_perf("rst load");

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (n % 2 == 0) ? $urandom : 32'($urandom_range(0, 63));
            xact(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
                 $urandom_range(0, 2), "rand", got, gerr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
Parametrised load/store unit with an integrated byte-addressed data RAM. It is the successor to the word-only data memory and the separate load/store sign-handling blocks. It accepts one RV32I load or store per valid/ready handshake and performs byte-lane selection, sign or zero extension and alignment checking. It returns the result after a configurable wait-state latency through a valid/ready response channel, so a multi-cycle core can stall on memory.

Parameters:
XLEN, 32, data and address width (only 32 is supported).
DEPTH_WORDS, 1024, RAM depth in XLEN-bit words; power of two, at least 4.
LATENCY, 1, extra wait cycles between request acceptance and response; range 0..15.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data; the low byte or halfword is used for SB/SH
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  XLEN  extended load data; 0 for stores and on error
rsp_err  output  1  misaligned access or illegal funct3

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. Only one request is outstanding at a time.
  - IDLE: req_ready=1. On req_valid && req_ready at an edge, the request is accepted. The next state is RESP if LATENCY=0, otherwise WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. The counter decrements each edge. When it is 0, the next state is RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge, then the next state is IDLE.
- Response latency: rsp_valid is first high in the cycle after acceptance edge + LATENCY edges.
- Throughput: a new request can be accepted no earlier than the cycle after the response handshake. req_ready is a registered function of state, with no combinational path from rsp_ready.
- Addressing: little-endian. Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the RAM size.
- Load funct3 encodings:
  - 000 LB, sign-extend the byte at addr[1:0].
  - 001 LH, sign-extend the halfword at addr[1].
  - 010 LW, full word.
  - 100 LBU, zero-extend the byte.
  - 101 LHU, zero-extend the halfword.
  - 011, 110, 111 are illegal.
- Store funct3 encodings: 000 SB, 001 SH, 010 SW. All other values are illegal.
- Alignment: a halfword access with addr[0]=1 is misaligned. A word access with addr[1:0]≠0 is misaligned. Misaligned or illegal requests perform no RAM access and respond with rsp_err=1 and rsp_rdata=0 after the normal latency.
- Timing of RAM access: a store writes only its byte lanes, on the acceptance edge. Load data is read on the acceptance edge and registered. A store followed by a load of the same address returns the new data.
- Reset priority: reset has priority over everything. If reset is asserted on an acceptance edge, no write occurs. Reset during WAIT or RESP drops the pending response and returns the FSM to IDLE; any store already accepted remains committed.
- req_wdata, req_addr and req_funct3 are ignored when not accepted.

Optional Feature:
Macro: LSU_PERF_CNT_EN.
- When defined, three 32-bit output ports are added: perf_loads, perf_stores and perf_errors.
  - perf_loads and perf_stores increment on each accepted error-free load and store respectively.
  - perf_errors increments on each accepted request that will respond with rsp_err=1.
  - All three reset to 0 and wrap from 0xFFFFFFFF to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg contains:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state typedef lsu_state_t {IDLE, WAIT, RESP};
  - a width-check constant for LATENCY.
- Sub-module lsu_align is purely combinational. From funct3, addr[1:0] and wdata it produces byte-enable[3:0], the lane-shifted write word and an illegal/misaligned flag. It also extends a read word into rdata.
- lsu_mem holds the FSM, the counter, the RAM and the response registers.

Test Plan:
- Sub-word stores and loads (LATENCY=1): SW 0xDEADBEEF @0x10.
  - LB @0x13 → 0xFFFFFFDE.
  - LBU @0x13 → 0x000000DE.
  - LH @0x12 → 0xFFFFDEAD.
  - LHU @0x10 → 0x0000BEEF.
- Byte-lane write: SB wdata=0x12345655 @0x11, then LW @0x10 → 0xDEAD55EF, rsp_err=0.
- Misaligned and illegal requests: LW @0x12 → rsp_err=1, rdata=0; SH @0x11 → rsp_err=1. A following LW @0x10 shows the word unchanged. funct3=011 load → rsp_err=1.
- Latency and backpressure (LATENCY=3): accept at edge t → rsp_valid rises after edge t+3. With rsp_ready held 0 for 2 cycles, rsp_valid and rsp_rdata stay stable and req_ready stays 0. req_ready=1 the cycle after the handshake.
- Address wrap (DEPTH_WORDS=1024): SW 0xA5A5A5A5 @0x1000 then LW @0x0 → 0xA5A5A5A5.
- Reset during WAIT (LATENCY=3): accept LW, assert reset for 1 cycle after edge t+1 → rsp_valid never rises and req_ready=1 after reset. With LSU_PERF_CNT_EN defined, all counters read 0 after the reset.
